seg7_reader: RTL and testbench

// Reverse path of the 4-bit encoder/display block. On a ready strobe it captures four
// 7-segment digit patterns (display3..display0) and scans them one digit per clock.
// It decodes each pattern to a decimal digit and accumulates the 4-digit decimal number
// as a binary value.
// It also flags any pattern that is not a legal digit. It sits on the display bus and

---
 rtl/seg7_reader.sv | 116 +++++++++++
 tb/tb_seg7_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: captures four 7-segment digit patterns, decodes them one per clock
// and accumulates the 4-digit decimal number as binary, flagging illegal patterns.
module seg7_reader #(
    parameter bit SEG_INVERT    = 1'b0,
    parameter bit BLANK_IS_ZERO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic [6:0]  display3,
    input  logic [6:0]  display2,
    input  logic [6:0]  display1,
    input  logic [6:0]  display0,
    output logic [13:0] valor,
    output logic        valid,
    output logic        erro,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0][6:0]   cap;
    logic [1:0]        idx;
    logic [13:0]       acc;
    logic [13:0]       acc_next;
    logic              err;
    logic [6:0]        pattern;
    logic [3:0]        digit;
    logic              bad;

    // Decode the digit currently selected by idx; illegal patterns count as 0.
    always_comb begin
        pattern = cap[idx] ^ {7{SEG_INVERT}};
        digit   = 4'd0;
        bad     = 1'b0;
        case (pattern)
            7'b1111110: digit = 4'd0;
            7'b0110000: digit = 4'd1;
            7'b1101101: digit = 4'd2;
            7'b1111001: digit = 4'd3;
            7'b0110011: digit = 4'd4;
            7'b1011011: digit = 4'd5;
            7'b1011111: digit = 4'd6;
            7'b1110000: digit = 4'd7;
            7'b1111111: digit = 4'd8;
            7'b1111011: digit = 4'd9;
            7'b0000000: bad   = !BLANK_IS_ZERO;
            default:    bad   = 1'b1;
        endcase
        acc_next = (acc << 3) + (acc << 1) + {10'd0, digit};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ready) state_next = SCAN;
            SCAN:    if (idx == 2'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture on accept, then fold one digit per cycle, most significant first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap   <= '0;
            idx   <= 2'd0;
            acc   <= 14'd0;
            err   <= 1'b0;
            valor <= 14'd0;
            erro  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready) begin
                        cap <= {display3, display2, display1, display0};
                        acc <= 14'd0;
                        err <= 1'b0;
                        idx <= 2'd3;
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    err <= err | bad;
                    idx <= idx - 2'd1;
                    if (idx == 2'd0) begin
                        valor <= acc_next;
                        erro  <= err | bad;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        valid = (state == DONE);
        busy  = (state != IDLE);
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: three instances (default, blank illegal,
// inverted segments) compared against a digit-table reference model.
module tb_seg7_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic [6:0]  display3, display2, display1, display0;
    logic [6:0]  inv3, inv2, inv1, inv0;
    logic [13:0] valor_a, valor_b, valor_c;
    logic        valid_a, valid_b, valid_c;
    logic        erro_a, erro_b, erro_c;
    logic        busy_a, busy_b, busy_c;

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] legal [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    always #5 clock = ~clock;

    assign inv3 = ~display3;
    assign inv2 = ~display2;
    assign inv1 = ~display1;
    assign inv0 = ~display0;

    seg7_reader #(.SEG_INVERT(1'b0), .BLANK_IS_ZERO(1'b1)) dut_a (
        .clock(clock), .reset(reset), .ready(ready),
        .display3(display3), .display2(display2), .display1(display1), .display0(display0),
        .valor(valor_a), .valid(valid_a), .erro(erro_a), .busy(busy_a));

    seg7_reader #(.SEG_INVERT(1'b0), .BLANK_IS_ZERO(1'b0)) dut_b (
        .clock(clock), .reset(reset), .ready(ready),
        .display3(display3), .display2(display2), .display1(display1), .display0(display0),
        .valor(valor_b), .valid(valid_b), .erro(erro_b), .busy(busy_b));

    seg7_reader #(.SEG_INVERT(1'b1), .BLANK_IS_ZERO(1'b1)) dut_c (
        .clock(clock), .reset(reset), .ready(ready),
        .display3(inv3), .display2(inv2), .display1(inv1), .display0(inv0),
        .valor(valor_c), .valid(valid_c), .erro(erro_c), .busy(busy_c));

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int refDigit(input logic [6:0] p, input bit blank_ok, output bit bad);
        bad = 1'b0;
        for (int i = 0; i < 10; i++)
            if (p == legal[i]) return i;
        if (p == 7'b0000000 && blank_ok) return 0;
        bad = 1'b1;
        return 0;
    endfunction

    // Reference value = sum of digit * decimal weight; error = any digit illegal.
    task automatic checkResults(input logic [6:0] p3, input logic [6:0] p2,
                                input logic [6:0] p1, input logic [6:0] p0);
        logic [6:0] pats [4];
        int weight [4];
        int exp_val;
        bit err_a, err_b, bad;
        int d;
        pats   = '{p3, p2, p1, p0};
        weight = '{1000, 100, 10, 1};
        exp_val = 0;
        err_a = 1'b0;
        err_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = refDigit(pats[i], 1'b1, bad);
            exp_val += d * weight[i];
            err_a |= bad;
            d = refDigit(pats[i], 1'b0, bad);
            err_b |= bad;
        end
        checkOutput("valid_a", int'(valid_a), 1);
        checkOutput("busy_done", int'(busy_a), 1);
        checkOutput("valor_a", int'(valor_a), exp_val);
        checkOutput("erro_a", int'(erro_a), int'(err_a));
        checkOutput("valid_b", int'(valid_b), 1);
        checkOutput("valor_b", int'(valor_b), exp_val);
        checkOutput("erro_b", int'(erro_b), int'(err_b));
        checkOutput("valid_c", int'(valid_c), 1);
        checkOutput("valor_c", int'(valor_c), exp_val);
        checkOutput("erro_c", int'(erro_c), int'(err_a));
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
        end while (!valid_a && cycles < 12);
    endtask

    task automatic applyStimulus(input logic [6:0] p3, input logic [6:0] p2,
                                 input logic [6:0] p1, input logic [6:0] p0);
        int cycles;
        @(negedge clock);
        display3 = p3; display2 = p2; display1 = p1; display0 = p0;
        ready = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("busy_accept", int'(busy_a), 1);
        @(negedge clock);
        ready = 1'b0;
        display3 = 7'($urandom); display2 = 7'($urandom);
        display1 = 7'($urandom); display0 = 7'($urandom);
        waitValid(cycles);
        checkOutput("latency", cycles, 4);
        checkResults(p3, p2, p1, p0);
        @(posedge clock);
        #1;
        checkOutput("valid_drop", int'(valid_a), 0);
        checkOutput("busy_drop", int'(busy_a), 0);
    endtask

    function automatic logic [6:0] randomPattern();
        int r;
        logic [6:0] p;
        bit is_legal;
        r = $urandom_range(0, 9);
        if (r <= 7) return legal[$urandom_range(0, 9)];
        if (r == 8) return 7'b0000000;
        for (int t = 0; t < 50; t++) begin
            p = 7'($urandom_range(1, 127));
            is_legal = 1'b0;
            for (int i = 0; i < 10; i++)
                if (p == legal[i]) is_legal = 1'b1;
            if (!is_legal) return p;
        end
        return 7'b1010101;
    endfunction

    initial begin
        int cycles;
        int extra;
        int pulses;
        reset = 1'b0;
        ready = 1'b0;
        display3 = '0; display2 = '0; display1 = '0; display0 = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_valor", int'(valor_a), 0);
        checkOutput("reset_valid", int'(valid_a), 0);
        checkOutput("reset_erro", int'(erro_a), 0);
        checkOutput("reset_busy", int'(busy_a), 0);
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] directed conversions");
        applyStimulus(legal[1], legal[2], legal[3], legal[4]);
        checkOutput("valor_1234", int'(valor_a), 1234);
        applyStimulus(legal[9], legal[9], legal[9], legal[9]);
        checkOutput("valor_9999", int'(valor_a), 9999);
        applyStimulus(legal[0], legal[0], legal[0], legal[0]);
        applyStimulus(legal[5], legal[5], 7'b1010101, legal[5]);
        checkOutput("valor_5505", int'(valor_a), 5505);
        checkOutput("erro_illegal", int'(erro_a), 1);
        applyStimulus(legal[5], legal[5], legal[5], legal[5]);
        checkOutput("erro_cleared", int'(erro_a), 0);
        applyStimulus(7'b0000000, 7'b0000000, legal[4], legal[2]);
        checkOutput("valor_42", int'(valor_a), 42);
        checkOutput("erro_blank_strict", int'(erro_b), 1);
        applyStimulus(legal[0], legal[7], legal[3], legal[6]);
        checkOutput("valor_736_inv", int'(valor_c), 736);

        $display("[TB] ready held high");
        @(negedge clock);
        display3 = legal[1]; display2 = legal[2]; display1 = legal[3]; display0 = legal[4];
        ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1;
        display3 = legal[8]; display2 = legal[8]; display1 = legal[8]; display0 = legal[8];
        waitValid(cycles);
        checkOutput("held_latency", cycles, 2);
        checkResults(legal[1], legal[2], legal[3], legal[4]);
        @(posedge clock);
        #1;
        waitValid(extra);
        checkOutput("held_period", 1 + extra, 6);
        checkResults(legal[8], legal[8], legal[8], legal[8]);
        @(negedge clock);
        ready = 1'b0;
        repeat (2) @(posedge clock);

        $display("[TB] reset mid-conversion");
        @(negedge clock);
        display3 = legal[1]; display2 = legal[2]; display1 = legal[3]; display0 = legal[4];
        ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_valor", int'(valor_a), 0);
        checkOutput("abort_busy", int'(busy_a), 0);
        checkOutput("abort_valid", int'(valid_a), 0);
        checkOutput("abort_erro", int'(erro_a), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (valid_a) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);
        applyStimulus(legal[4], legal[3], legal[2], legal[1]);

        $display("[TB] randomized conversions");
        for (int n = 0; n < 24; n++)
            applyStimulus(randomPattern(), randomPattern(), randomPattern(), randomPattern());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
